// File: rtl/nibble_sub_seq_pkg.sv
// Shared types and constants for the nibble-serial subtractor sequencer.
package nibble_sub_seq_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned STATE_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_sub_flags.sv
// Registered zero/neg/signed-overflow flags for the subtractor result.
// Only instantiated when NIBBLE_SUB_FLAGS_EN is defined.
module nibble_sub_flags
   import nibble_sub_seq_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_diff,
   input  logic         i_opa_msb,
   input  logic         i_opb_msb,
   output logic         o_zero,
   output logic         o_neg,
   output logic         o_ovf
);

   logic w_zero;
   logic w_neg;
   logic w_ovf;

   assign w_zero = (i_diff == '0);
   assign w_neg  = i_diff[W-1];
   // Signed overflow of opa-opb: operand signs differ and result sign flipped from opa.
   assign w_ovf  = (i_opa_msb != i_opb_msb) && (i_diff[W-1] != i_opa_msb);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_zero <= 1'b0;
         o_neg  <= 1'b0;
         o_ovf  <= 1'b0;
      end else if (i_load) begin
         o_zero <= w_zero;
         o_neg  <= w_neg;
         o_ovf  <= w_ovf;
      end
   end

endmodule

// File: rtl/nibble_sub_seq.sv
// Nibble-serial multi-word subtractor driving an external 4-bit subtractor.
// Optional result flags enabled with macro NIBBLE_SUB_FLAGS_EN (tied to 0 otherwise).
module nibble_sub_seq
   import nibble_sub_seq_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [NIBBLE_W*NIBBLES-1:0]   opa,
   input  logic [NIBBLE_W*NIBBLES-1:0]   opb,
   input  logic                          bin_init,
   output logic [NIBBLE_W-1:0]           sub_a,
   output logic [NIBBLE_W-1:0]           sub_b,
   output logic                          sub_bin,
   input  logic [NIBBLE_W-1:0]           sub_d,
   input  logic                          sub_bout,
   output logic [NIBBLE_W*NIBBLES-1:0]   diff,
   output logic                          bout,
   output logic                          zero,
   output logic                          neg,
   output logic                          ovf,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [W-1:0]     r_opa;
   logic [W-1:0]     r_opb;
   logic [W-1:0]     r_diff;
   logic [IDX_W-1:0] r_idx;
   logic             r_borrow;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;
   logic             w_last;
   logic             w_flag_load;

   assign w_last      = (r_idx == LAST_IDX);
   assign w_flag_load = (r_state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RUN;
         RUN:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa    <= '0;
         r_opb    <= '0;
         r_diff   <= '0;
         r_idx    <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_opa    <= opa;
                  r_opb    <= opb;
                  r_borrow <= bin_init;
                  r_idx    <= '0;
                  r_busy   <= 1'b1;
               end
            end
            RUN: begin
               r_diff[r_idx*NIBBLE_W +: NIBBLE_W] <= sub_d;
               r_borrow                           <= sub_bout;
               if (w_last) begin
                  r_bout <= sub_bout;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Subtractor operands come straight from registers; idle/done states drive zeros.
   always_comb begin
      sub_a   = '0;
      sub_b   = '0;
      sub_bin = 1'b0;
      if (r_state == RUN) begin
         sub_a   = r_opa[r_idx*NIBBLE_W +: NIBBLE_W];
         sub_b   = r_opb[r_idx*NIBBLE_W +: NIBBLE_W];
         sub_bin = r_borrow;
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;
   assign busy = r_busy;
   assign done = r_done;

`ifdef NIBBLE_SUB_FLAGS_EN
   nibble_sub_flags #(
      .W (W)
   ) u_flags (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_load    (w_flag_load),
      .i_diff    (r_diff),
      .i_opa_msb (r_opa[W-1]),
      .i_opb_msb (r_opb[W-1]),
      .o_zero    (zero),
      .o_neg     (neg),
      .o_ovf     (ovf)
   );
`else
   assign zero = 1'b0;
   assign neg  = 1'b0;
   assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_sub_seq.sv
// Self-checking bench for nibble_sub_seq against an arithmetic reference model.
module tb_nibble_sub_seq;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b1;
   logic           start    = 1'b0;
   logic           bin_init = 1'b0;
   logic [W-1:0]   opa      = '0;
   logic [W-1:0]   opb      = '0;
   logic [W-1:0]   diff;
   logic [3:0]     sub_a;
   logic [3:0]     sub_b;
   logic [3:0]     sub_d;
   logic           sub_bin;
   logic           sub_bout;
   logic           bout;
   logic           zero;
   logic           neg;
   logic           ovf;
   logic           busy;
   logic           done;
   logic [4:0]     w_sub;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] m_diff;
   logic         m_bout;
   logic         m_zero;
   logic         m_neg;
   logic         m_ovf;

   always #5 clk = ~clk;

   // External 4-bit subtractor
   assign w_sub    = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_bin};
   assign sub_d    = w_sub[3:0];
   assign sub_bout = w_sub[4];

   nibble_sub_seq #(
      .NIBBLES (NIB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opa      (opa),
      .opb      (opb),
      .bin_init (bin_init),
      .sub_a    (sub_a),
      .sub_b    (sub_b),
      .sub_bin  (sub_bin),
      .sub_d    (sub_d),
      .sub_bout (sub_bout),
      .diff     (diff),
      .bout     (bout),
      .zero     (zero),
      .neg      (neg),
      .ovf      (ovf),
      .busy     (busy),
      .done     (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      int d;
      d      = int'(a) - int'(b) - int'(bi);
      m_bout = (d < 0);
      if (d < 0) d = d + (1 << W);
      m_diff = W'(d);
`ifdef NIBBLE_SUB_FLAGS_EN
      m_zero = (m_diff == '0);
      m_neg  = m_diff[W-1];
      m_ovf  = (a[W-1] != b[W-1]) && (m_diff[W-1] != a[W-1]);
`else
      m_zero = 1'b0;
      m_neg  = 1'b0;
      m_ovf  = 1'b0;
`endif
   endtask

   task automatic wait_done(input string tag, input int k0);
      int k;
      k = k0;
      while (!done && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_lat"}, k, NIB + 1);
      check({tag, "_diff"}, diff, m_diff);
      check({tag, "_bout"}, bout, m_bout);
      check({tag, "_zero"}, zero, m_zero);
      check({tag, "_neg"}, neg, m_neg);
      check({tag, "_ovf"}, ovf, m_ovf);
      check({tag, "_busy_off"}, busy, 0);
   endtask

   // Called at posedge+1; returns in the done cycle so a following call is back-to-back.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi);
      model(a, b, bi);
      opa = a; opb = b; bin_init = bi; start = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      opa      = W'($urandom);
      opb      = W'($urandom);
      bin_init = 1'($urandom);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_sub_a0"}, sub_a, a[3:0]);
      check({tag, "_sub_b0"}, sub_b, b[3:0]);
      check({tag, "_sub_bin0"}, sub_bin, bi);
      wait_done(tag, 0);
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      check({tag, "_done_off"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_sub"}, {sub_a, sub_b, sub_bin}, 0);
      check({tag, "_hold_diff"}, diff, m_diff);
      check({tag, "_hold_bout"}, bout, m_bout);
   endtask

   initial begin
      int pulses;
      int k;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outs", {diff, bout, zero, neg, ovf, busy, done}, 0);
      check("rst_sub", {sub_a, sub_b, sub_bin}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("d033", 16'h1234, 16'h0034, 1'b0);
      check("d033_lit", diff, 16'h1200);
      idle_check("d033");

      run_op("d034", 16'h0000, 16'h0001, 1'b0);
      check("d034_lit", {bout, diff}, 17'h1FFFF);
      idle_check("d034");

      run_op("d035a", 16'h8000, 16'h0001, 1'b0);
      check("d035a_lit", diff, 16'h7FFF);
      run_op("d035b", 16'h0005, 16'h0003, 1'b1);
      check("d035b_lit", diff, 16'h0001);
      run_op("d035c", 16'hABCD, 16'hABCD, 1'b0);
      check("d035c_lit", diff, 16'h0000);
      idle_check("d035c");

      // start pulsed in the second RUN cycle must be ignored
      model(16'h1234, 16'h0034, 1'b0);
      opa = 16'h1234; opb = 16'h0034; bin_init = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      opa = 16'hFFFF; opb = 16'h0001; bin_init = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign_busy", busy, 1);
      wait_done("ign", 2);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("ign_pulses", pulses, 0);

      // asynchronous reset in the third RUN cycle
      opa = 16'h5555; opb = 16'h1111; bin_init = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mrst_outs", {diff, bout, zero, neg, ovf, busy, done}, 0);
      check("mrst_sub", {sub_a, sub_b, sub_bin}, 0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("mrst_pulses", pulses, 0);
      @(negedge clk) rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      check("mrst_quiet", pulses, 0);
      run_op("d037", 16'h0010, 16'h0001, 1'b0);
      check("d037_lit", diff, 16'h000F);
      idle_check("d037");

      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = (($urandom % 6) == 0) ? ra : W'($urandom);
         run_op("rnd", ra, rb, 1'($urandom));
         k = int'($urandom % 3);
         for (int j = 0; j < k; j++) idle_check("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nibble_sub_seq.md
NIBBLE_SUB_SEQ -- requirements
Module: nibble_sub_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: operand width in 4-bit nibbles, legal range 2..8.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request a subtraction; accepted only when busy=0.
REQ-005 SHALL have port opa, input, 4*NIBBLES: minuend.
REQ-006 SHALL have port opb, input, 4*NIBBLES: subtrahend.
REQ-007 SHALL have port bin_init, input, 1: initial borrow-in.
REQ-008 SHALL have ports sub_a, sub_b, output, 4 each: nibble operands driven to the external 4-bit subtractor.
REQ-009 SHALL have port sub_bin, output, 1: borrow-in driven to the external subtractor.
REQ-010 SHALL have ports sub_d, input, 4, and sub_bout, input, 1: combinational difference and borrow-out returned by the subtractor.
REQ-011 SHALL have port diff, output, 4*NIBBLES: registered full-width difference.
REQ-012 SHALL have port bout, output, 1: registered final borrow-out.
REQ-013 SHALL have ports zero, neg, ovf, output, 1 each: result flags.
REQ-014 SHALL have port busy, output, 1, and port done, output, 1: done is a one-cycle completion pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; reset state is IDLE.
REQ-016 In IDLE with start=1: SHALL latch opa, opb and bin_init, clear nibble index idx to 0, load the borrow register from bin_init, and enter RUN; busy=1 from the next cycle.
REQ-017 In RUN, SHALL drive sub_a=opa_r[idx], sub_b=opb_r[idx] and sub_bin=borrow register, all from registers.
REQ-018 In RUN, each cycle SHALL write sub_d into diff nibble idx, load sub_bout into the borrow register, and increment idx.
REQ-019 When idx=NIBBLES-1 in RUN, SHALL capture the last nibble, set bout=sub_bout and enter DONE.
REQ-020 In DONE, SHALL assert done for exactly one cycle with diff, bout and flags valid, then return to IDLE with busy=0.
REQ-021 Latency SHALL be NIBBLES+1 cycles from the start-accept edge to done=1.
REQ-022 start while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-023 start in the cycle after done SHALL be accepted, which gives back-to-back throughput of one operation per NIBBLES+2 cycles.
REQ-024 diff, bout and the flags SHALL hold their last values until the next operation overwrites them.
REQ-025 zero SHALL equal (diff==0), neg SHALL equal diff MSB, and ovf SHALL equal (opa_r MSB != opb_r MSB) AND (diff MSB != opa_r MSB); all three SHALL be registered and updated in DONE.
REQ-026 In IDLE and DONE, sub_a, sub_b and sub_bin SHALL be driven to 0.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and clear idx, borrow, diff, bout, zero, neg, ovf, busy, done, sub_a, sub_b and sub_bin to 0, including mid-RUN; no done pulse SHALL follow.
REQ-028 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro NIBBLE_SUB_FLAGS_EN defined: zero, neg and ovf SHALL behave per REQ-025.
REQ-030 Macro NIBBLE_SUB_FLAGS_EN undefined: zero, neg and ovf SHALL be tied to 0, no flag logic SHALL be generated, and ports SHALL be unchanged.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE), the NIBBLE_W=4 constant and the state encoding width.
REQ-032 Flag computation SHALL be one sub-module, nibble_sub_flags, instantiated only under NIBBLE_SUB_FLAGS_EN; the bench SHALL connect the team's 4-bit subtractor to the sub_* ports.

Verification
REQ-033 NIBBLES=4, opa=0x1234, opb=0x0034, bin_init=0 -> done on the 5th cycle after accept, diff=0x1200, bout=0, zero=0, neg=0, ovf=0.
REQ-034 opa=0x0000, opb=0x0001 -> diff=0xFFFF, bout=1, neg=1, zero=0, ovf=0.
REQ-035 opa=0x8000, opb=0x0001 -> diff=0x7FFF, ovf=1, neg=0; opa=0x0005, opb=0x0003, bin_init=1 -> diff=0x0001; opa=opb=0xABCD -> zero=1.
REQ-036 start pulsed with new operands while busy (2nd RUN cycle) -> ignored, first result unchanged, a single done pulse.
REQ-037 rst_n low in the 3rd RUN cycle -> all outputs 0 at once, no done; a following start with 0x0010-0x0001 -> diff=0x000F.
REQ-038 Build without NIBBLE_SUB_FLAGS_EN, run REQ-034 -> diff and bout identical, zero=neg=ovf=0.
